// File: rtl/sram_req_arbiter.sv
// Two-master (IF / MEM) arbiter onto one SRAM-like slave port with in-order response routing.
// Optional macro ARB_ROUND_ROBIN_EN: alternate tie-break via a last_grant register.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        s_sram_req,
  output logic        s_sram_wr,
  output logic [1:0]  s_sram_size,
  output logic [3:0]  s_sram_wstrb,
  output logic [31:0] s_sram_addr,
  output logic [31:0] s_sram_wdata,
  input  logic        s_sram_addr_ok,
  input  logic        s_sram_data_ok,
  input  logic [31:0] s_sram_rdata,

  output logic        protocol_err
);

  localparam int unsigned ID_W  = $clog2(OUTSTANDING) + 1;
  localparam int unsigned PTR_W = $clog2(OUTSTANDING);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

  state_e                 state_q;
  logic [ID_W-1:0]        cnt_q;
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING-1:0] owner_q;
  logic                   perr_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                   last_grant_q;
`endif

  logic gnt_vld, gnt_d, req_sel, fifo_full, accept, push, pop, head;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_d   = 1'b0;
    unique case (state_q)
      LOCK_I: begin
        gnt_vld = 1'b1;
        gnt_d   = 1'b0;
      end
      LOCK_D: begin
        gnt_vld = 1'b1;
        gnt_d   = 1'b1;
      end
      default: begin
        gnt_vld = inst_sram_req | data_sram_req;
`ifdef ARB_ROUND_ROBIN_EN
        if (inst_sram_req && data_sram_req) gnt_d = ~last_grant_q;
        else                                gnt_d = data_sram_req;
`else
        gnt_d = data_sram_req;
`endif
      end
    endcase
  end

  assign fifo_full = (cnt_q == ID_W'(OUTSTANDING));
  assign req_sel   = gnt_d ? data_sram_req : inst_sram_req;
  assign s_sram_req = gnt_vld & req_sel & ~fifo_full;
  assign accept    = s_sram_req & s_sram_addr_ok;
  assign push      = accept;
  assign pop       = s_sram_data_ok & (cnt_q != '0);
  assign head      = owner_q[rd_ptr_q];

  always_comb begin
    s_sram_wr    = 1'b0;
    s_sram_size  = '0;
    s_sram_wstrb = '0;
    s_sram_addr  = '0;
    s_sram_wdata = '0;
    if (gnt_vld) begin
      s_sram_wr    = gnt_d ? data_sram_wr    : inst_sram_wr;
      s_sram_size  = gnt_d ? data_sram_size  : inst_sram_size;
      s_sram_wstrb = gnt_d ? data_sram_wstrb : inst_sram_wstrb;
      s_sram_addr  = gnt_d ? data_sram_addr  : inst_sram_addr;
      s_sram_wdata = gnt_d ? data_sram_wdata : inst_sram_wdata;
    end
  end

  // addr_ok is qualified by the real accept so a full FIFO never acknowledges a dropped request
  assign inst_sram_addr_ok = accept & ~gnt_d;
  assign data_sram_addr_ok = accept &  gnt_d;
  assign inst_sram_data_ok = pop & ~head;
  assign data_sram_data_ok = pop &  head;
  assign inst_sram_rdata   = s_sram_rdata;
  assign data_sram_rdata   = s_sram_rdata;
  assign protocol_err      = perr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      owner_q  <= '0;
      perr_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        LOCK_I, LOCK_D: begin
          if (!req_sel || accept) state_q <= IDLE;
        end
        default: begin
          if (s_sram_req && !s_sram_addr_ok) state_q <= gnt_d ? LOCK_D : LOCK_I;
        end
      endcase

      if (push) begin
        owner_q[wr_ptr_q] <= gnt_d;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_q      <= gnt_d;
`endif
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (push && !pop)      cnt_q <= cnt_q + ID_W'(1);
      else if (pop && !push) cnt_q <= cnt_q - ID_W'(1);

      if (s_sram_data_ok && cnt_q == '0) perr_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed-vector bench for sram_req_arbiter; honours ARB_ROUND_ROBIN_EN for the tie-break test.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        s_sram_req, s_sram_wr;
  logic [1:0]  s_sram_size;
  logic [3:0]  s_sram_wstrb;
  logic [31:0] s_sram_addr, s_sram_wdata;
  logic        s_sram_addr_ok, s_sram_data_ok;
  logic [31:0] s_sram_rdata;
  logic        protocol_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] IA = 32'h1C00_0000;
  localparam logic [31:0] DA = 32'h0000_1000;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .s_sram_req(s_sram_req), .s_sram_wr(s_sram_wr), .s_sram_size(s_sram_size),
    .s_sram_wstrb(s_sram_wstrb), .s_sram_addr(s_sram_addr), .s_sram_wdata(s_sram_wdata),
    .s_sram_addr_ok(s_sram_addr_ok), .s_sram_data_ok(s_sram_data_ok),
    .s_sram_rdata(s_sram_rdata),
    .protocol_err(protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks happen 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd0; inst_sram_wstrb = 4'h0;
    inst_sram_addr = IA; inst_sram_wdata = 32'h0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd0; data_sram_wstrb = 4'h0;
    data_sram_addr = DA; data_sram_wdata = 32'h0;
    s_sram_addr_ok = 0; s_sram_data_ok = 0; s_sram_rdata = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    clear_in();
    do_reset();

    // reset state
    settle();
    check("rst_s_req", 32'(s_sram_req), 0);
    check("rst_addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    check("rst_data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 0);
    check("rst_perr", 32'(protocol_err), 0);
    check("rst_cnt", 32'(dut.cnt_q), 0);
    check("rst_s_addr_none", s_sram_addr, 0);

    // both request together: data wins
    inst_sram_req = 1; data_sram_req = 1; s_sram_addr_ok = 1;
    data_sram_wr = 1; data_sram_size = 2'd2; data_sram_wstrb = 4'hF; data_sram_wdata = 32'hDEAD_BEEF;
    settle();
    check("t1_s_addr", s_sram_addr, DA);
    check("t1_s_ctl", {25'd0, s_sram_wr, s_sram_size, s_sram_wstrb}, {25'd0, 1'b1, 2'd2, 4'hF});
    check("t1_s_wdata", s_sram_wdata, 32'hDEAD_BEEF);
    check("t1_d_aok", 32'(data_sram_addr_ok), 1);
    check("t1_i_aok", 32'(inst_sram_addr_ok), 0);
    tick();
    clear_in();
    settle();
    check("t1_cnt", 32'(dut.cnt_q), 1);
    s_sram_data_ok = 1; s_sram_rdata = 32'hCAFE_0001;
    settle();
    check("t1_rsp_owner", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'b01);
    check("t1_rdata_d", data_sram_rdata, 32'hCAFE_0001);
    check("t1_rdata_i", inst_sram_rdata, 32'hCAFE_0001);
    tick();
    clear_in();
    settle();
    check("t1_cnt_drain", 32'(dut.cnt_q), 0);

    // lock holds inst request against a later data request
    inst_sram_req = 1;
    settle();
    check("t2_c1_addr", s_sram_addr, IA);
    check("t2_c1_req", 32'(s_sram_req), 1);
    tick();
    data_sram_req = 1;
    settle();
    check("t2_c2_addr", s_sram_addr, IA);
    tick();
    settle();
    check("t2_c3_addr", s_sram_addr, IA);
    s_sram_addr_ok = 1;
    settle();
    check("t2_i_aok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'b10);
    tick();
    inst_sram_req = 0;
    settle();
    check("t2_d_addr", s_sram_addr, DA);
    check("t2_d_aok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'b01);
    tick();
    clear_in();
    settle();
    check("t2_cnt", 32'(dut.cnt_q), 2);
    s_sram_data_ok = 1;
    settle();
    check("t2_rsp0", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'b10);
    tick();
    settle();
    check("t2_rsp1", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'b01);
    tick();
    clear_in();

    // locked master withdraws: no push, back to idle
    inst_sram_req = 1;
    tick();
    inst_sram_req = 0; data_sram_req = 1;
    settle();
    check("t2b_frozen_req", 32'(s_sram_req), 0);
    tick();
    settle();
    check("t2b_d_addr", s_sram_addr, DA);
    check("t2b_cnt", 32'(dut.cnt_q), 0);
    clear_in();

    // fill to OUTSTANDING with I,D,I,D
    for (int i = 0; i < 4; i++) begin
      inst_sram_req = (i % 2 == 0); data_sram_req = (i % 2 == 1); s_sram_addr_ok = 1;
      settle();
      check("t3_push_aok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok},
            (i % 2 == 0) ? 32'b10 : 32'b01);
      tick();
    end
    data_sram_req = 0; inst_sram_req = 1;
    settle();
    check("t3_full_req", 32'(s_sram_req), 0);
    check("t3_full_aok", 32'(inst_sram_addr_ok), 0);
    tick();
    clear_in();
    settle();
    check("t3_cnt_full", 32'(dut.cnt_q), 4);
    for (int i = 0; i < 4; i++) begin
      s_sram_data_ok = 1; s_sram_rdata = 32'h11 * (i + 1);
      settle();
      check("t3_rsp_owner", {30'd0, inst_sram_data_ok, data_sram_data_ok},
            (i % 2 == 0) ? 32'b10 : 32'b01);
      check("t3_rsp_rdata", (i % 2 == 0) ? inst_sram_rdata : data_sram_rdata, 32'h11 * (i + 1));
      tick();
    end
    clear_in();
    settle();
    check("t3_cnt_empty", 32'(dut.cnt_q), 0);

    // simultaneous push and pop at count 1
    inst_sram_req = 1; s_sram_addr_ok = 1;
    tick();
    inst_sram_req = 0; data_sram_req = 1; s_sram_data_ok = 1;
    settle();
    check("t4_pop_owner", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'b10);
    check("t4_d_aok", 32'(data_sram_addr_ok), 1);
    tick();
    clear_in();
    settle();
    check("t4_cnt", 32'(dut.cnt_q), 1);
    s_sram_data_ok = 1;
    settle();
    check("t4_next_owner", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 32'b01);
    tick();
    clear_in();

    // data_ok with empty FIFO
    s_sram_data_ok = 1;
    settle();
    check("t5_no_dok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 0);
    tick();
    s_sram_data_ok = 0;
    settle();
    check("t5_perr_set", 32'(protocol_err), 1);
    tick(); tick();
    settle();
    check("t5_perr_hold", 32'(protocol_err), 1);
    check("t5_cnt", 32'(dut.cnt_q), 0);
    do_reset();
    settle();
    check("t5_perr_clr", 32'(protocol_err), 0);

    // continuous tie: round-robin alternates D,I,D,I; fixed priority keeps D
    inst_sram_req = 1; data_sram_req = 1; s_sram_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      check("t6_tie_grant", {30'd0, inst_sram_addr_ok, data_sram_addr_ok},
            (i % 2 == 0) ? 32'b01 : 32'b10);
`else
      check("t6_tie_grant", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 32'b01);
`endif
      tick();
    end
    clear_in();
    settle();
    check("t6_cnt", 32'(dut.cnt_q), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
